// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin lock arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_HOLD_W = 8;

  // Index width for an N-entry vector; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority picker: the first set bit of (req & ~excl), scanning from ptr upward mod N.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  assign masked = req_i & ~excl_i;
  assign dbl    = {masked, masked};
  assign rot    = N'(dbl >> ptr_i);

  // Lowest set bit of the rotated vector is the offset from ptr.
  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = IW'(i);
      end
    end
    sum = (IW + 1)'(ptr_i) + (IW + 1)'(off);
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    idx_o = IW'(sum);
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking and zero-gap hand-off.
// Define ARB_TIMEOUT_EN to force a hand-off after MAX_HOLD cycles when others are waiting.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [idx_w(N)-1:0]  gnt_id
);

  localparam int unsigned IW = idx_w(N);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          rel;
  logic          found;
  logic [IW-1:0] win;

`ifdef ARB_TIMEOUT_EN
  localparam logic [ARB_HOLD_W-1:0] HOLD_SAT  = ARB_HOLD_W'(MAX_HOLD);
  localparam logic [ARB_HOLD_W-1:0] HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

  logic [ARB_HOLD_W-1:0] hold_q, hold_d;
`else
  // Without the timeout the hold limit has no effect; grants last while req is held.
  if (MAX_HOLD == 0) begin : g_unused_max_hold
  end
`endif

  // The current grant doubles as the exclusion mask: zero in IDLE, owner one-hot in BUSY.
  arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .excl_i  (gnt_q),
    .found_o (found),
    .idx_o   (win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif

    if (state_q == ARB_IDLE) begin
      rel = 1'b1;
    end else if (!req[id_q]) begin
      rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
    end else if ((hold_q >= HOLD_LAST) && (|(req & ~gnt_q))) begin
      rel = 1'b1;
`endif
    end

    if (rel) begin
      if (found) begin
        state_d = ARB_BUSY;
        gnt_d   = N'(1) << win;
        id_d    = win;
        valid_d = 1'b1;
        ptr_d   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      hold_d = '0;
    end else if (hold_q < HOLD_SAT) begin
      hold_d = hold_q + ARB_HOLD_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;

endmodule
